// File: rtl/ulpi_phy_emu.sv
// PHY-side ULPI emulator: register file, TX packet capture, and RX data / RX CMD generation.
// Outputs are registered; the comb block computes the values for the next cycle.
module ulpi_phy_emu #(
   parameter int          NUM_REGS        = 16,
   parameter logic [15:0] VENDOR_ID       = 16'h0424,
   parameter logic [15:0] PRODUCT_ID      = 16'h0009,
   parameter int          TX_NXT_GAP      = 0,
   parameter bit          RXCMD_ON_CHANGE = 1'b1
) (
   input  logic       ulpi_clk,
   input  logic       ulpi_reset,
   input  logic [7:0] ulpi_data_in,
   output logic [7:0] ulpi_data_out,
   output logic       ulpi_data_oe,
   output logic       ulpi_direction,
   output logic       ulpi_nxt,
   input  logic       ulpi_stp,
   input  logic [1:0] linestate,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       rx_last,
   output logic       rx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   output logic       tx_done
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [3:0] {
      IDLE, WR_CMD, WR_DATA, WR_STP, RD_CMD, RD_TURN, RD_DATA, RD_BACK,
      TX, TURN_IN, RX_DATA, RXCMD, TURN_OUT
   } state_t;

   state_t      state, state_n;
   logic [5:0]  addr, addr_n;
   logic [7:0]  wdata, wdata_n;
   logic        pkt, pkt_n;
   logic        tx_first, tx_first_n;
   logic [15:0] gap_cnt, gap_cnt_n;
   logic        rx_done, rx_done_n;
   logic [1:0]  last_ls, last_ls_n;
   logic [7:0]  data_out_n, tx_data_n, rd_val;
   logic        oe_n, dir_n, nxt_n, rx_ready_n, tx_valid_n, tx_done_n, commit;
   logic [7:0]  reg_file [NUM_REGS];

   function automatic logic [7:0] rx_cmd(input logic [1:0] ev, input logic [1:0] ls);
      return {2'b00, ev, 2'b11, ls};
   endfunction

   always_comb begin
      rd_val = 8'h00;
      if (int'(addr) < NUM_REGS) rd_val = reg_file[addr[AW-1:0]];
   end

   always_comb begin
      state_n    = state;
      addr_n     = addr;
      wdata_n    = wdata;
      pkt_n      = pkt;
      tx_first_n = tx_first;
      gap_cnt_n  = gap_cnt;
      rx_done_n  = rx_done;
      last_ls_n  = last_ls;
      data_out_n = 8'h00;
      oe_n       = 1'b0;
      dir_n      = 1'b0;
      nxt_n      = 1'b0;
      rx_ready_n = 1'b0;
      tx_valid_n = 1'b0;
      tx_data_n  = tx_data;
      tx_done_n  = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            // Link commands take priority over injected RX and linestate reports
            if (ulpi_data_in[7:6] == 2'b10) begin
               state_n = WR_CMD;
               addr_n  = ulpi_data_in[5:0];
               nxt_n   = 1'b1;
            end else if (ulpi_data_in[7:6] == 2'b11) begin
               state_n = RD_CMD;
               addr_n  = ulpi_data_in[5:0];
               nxt_n   = 1'b1;
            end else if (ulpi_data_in[7:6] == 2'b01) begin
               state_n    = TX;
               nxt_n      = 1'b1;
               tx_valid_n = 1'b1;
               tx_data_n  = {4'h0, ulpi_data_in[3:0]};
               tx_first_n = 1'b1;
               gap_cnt_n  = 16'd0;
            end else if (rx_valid) begin
               state_n = TURN_IN;
               pkt_n   = 1'b1;
               dir_n   = 1'b1;
               nxt_n   = 1'b1;
            end else if (RXCMD_ON_CHANGE && (linestate != last_ls)) begin
               state_n = TURN_IN;
               pkt_n   = 1'b0;
               dir_n   = 1'b1;
            end
         end
         WR_CMD: begin
            state_n = WR_DATA;
            nxt_n   = 1'b1;
         end
         WR_DATA: begin
            state_n = WR_STP;
            wdata_n = ulpi_data_in;
         end
         WR_STP: begin
            if (ulpi_stp) begin
               state_n = IDLE;
               commit  = (int'(addr) < NUM_REGS) && (addr > 6'd3);
            end
         end
         RD_CMD: begin
            state_n = RD_TURN;
            dir_n   = 1'b1;
         end
         RD_TURN: begin
            state_n    = RD_DATA;
            dir_n      = 1'b1;
            oe_n       = 1'b1;
            data_out_n = rd_val;
         end
         RD_DATA: state_n = RD_BACK;
         RD_BACK: state_n = IDLE;
         TX: begin
            // The first TX cycle still carries the command byte, so nothing is captured
            nxt_n = 1'b1;
            if (ulpi_stp) begin
               state_n   = IDLE;
               nxt_n     = 1'b0;
               tx_done_n = 1'b1;
            end else if (tx_first) begin
               tx_first_n = 1'b0;
            end else if (ulpi_nxt) begin
               tx_valid_n = 1'b1;
               tx_data_n  = ulpi_data_in;
               if (TX_NXT_GAP != 0 && int'(gap_cnt) + 1 == TX_NXT_GAP) begin
                  nxt_n     = 1'b0;
                  gap_cnt_n = 16'd0;
               end else begin
                  gap_cnt_n = gap_cnt + 16'd1;
               end
            end
         end
         TURN_IN: begin
            dir_n = 1'b1;
            oe_n  = 1'b1;
            if (pkt) begin
               state_n    = RX_DATA;
               rx_done_n  = 1'b0;
               data_out_n = rx_cmd(2'b01, linestate);
            end else begin
               state_n    = RXCMD;
               data_out_n = rx_cmd(2'b00, linestate);
               last_ls_n  = linestate;
            end
         end
         RX_DATA: begin
            // rx_done keeps the final byte on the bus for one cycle before turnaround
            if (rx_done) begin
               state_n = TURN_OUT;
            end else begin
               dir_n = 1'b1;
               oe_n  = 1'b1;
               if (rx_valid) begin
                  nxt_n      = 1'b1;
                  data_out_n = rx_data;
                  rx_ready_n = 1'b1;
                  rx_done_n  = rx_last;
               end else begin
                  data_out_n = rx_cmd(2'b01, linestate);
               end
            end
         end
         RXCMD:    state_n = TURN_OUT;
         TURN_OUT: state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   always_ff @(posedge ulpi_clk or posedge ulpi_reset) begin
      if (ulpi_reset) begin
         state          <= IDLE;
         addr           <= 6'd0;
         wdata          <= 8'h00;
         pkt            <= 1'b0;
         tx_first       <= 1'b0;
         gap_cnt        <= 16'd0;
         rx_done        <= 1'b0;
         last_ls        <= linestate;
         ulpi_data_out  <= 8'h00;
         ulpi_data_oe   <= 1'b0;
         ulpi_direction <= 1'b0;
         ulpi_nxt       <= 1'b0;
         rx_ready       <= 1'b0;
         tx_valid       <= 1'b0;
         tx_data        <= 8'h00;
         tx_done        <= 1'b0;
      end else begin
         state          <= state_n;
         addr           <= addr_n;
         wdata          <= wdata_n;
         pkt            <= pkt_n;
         tx_first       <= tx_first_n;
         gap_cnt        <= gap_cnt_n;
         rx_done        <= rx_done_n;
         last_ls        <= last_ls_n;
         ulpi_data_out  <= data_out_n;
         ulpi_data_oe   <= oe_n;
         ulpi_direction <= dir_n;
         ulpi_nxt       <= nxt_n;
         rx_ready       <= rx_ready_n;
         tx_valid       <= tx_valid_n;
         tx_data        <= tx_data_n;
         tx_done        <= tx_done_n;
      end
   end

   always_ff @(posedge ulpi_clk or posedge ulpi_reset) begin
      if (ulpi_reset) begin
         for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= 8'h00;
         reg_file[0] <= VENDOR_ID[7:0];
         reg_file[1] <= VENDOR_ID[15:8];
         reg_file[2] <= PRODUCT_ID[7:0];
         reg_file[3] <= PRODUCT_ID[15:8];
      end else if (commit) begin
         reg_file[addr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// Bench for ulpi_phy_emu: the bench plays the ULPI link and the RX packet source,
// comparing bus traffic against a register-file model and packet queues.
module tb_ulpi_phy_emu;

   localparam int          NREGS  = 16;
   localparam int          TX_GAP = 2;
   localparam logic [15:0] VID    = 16'h0424;
   localparam logic [15:0] PID    = 16'h0009;

   logic       ulpi_clk = 1'b0;
   logic       ulpi_reset = 1'b1;
   logic [7:0] ulpi_data_in = 8'h00;
   logic [7:0] ulpi_data_out;
   logic       ulpi_data_oe, ulpi_direction, ulpi_nxt;
   logic       ulpi_stp = 1'b0;
   logic [1:0] linestate = 2'b00;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_last = 1'b0;
   logic       rx_ready, tx_valid, tx_done;
   logic [7:0] tx_data;

   int checks = 0;
   int failures = 0;
   logic [7:0] model_regs [64];
   logic [7:0] tx_payload [$];
   logic [7:0] rx_pkt [$];

   ulpi_phy_emu #(
      .NUM_REGS(NREGS), .VENDOR_ID(VID), .PRODUCT_ID(PID),
      .TX_NXT_GAP(TX_GAP), .RXCMD_ON_CHANGE(1'b1)
   ) dut (
      .ulpi_clk(ulpi_clk), .ulpi_reset(ulpi_reset), .ulpi_data_in(ulpi_data_in),
      .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe),
      .ulpi_direction(ulpi_direction), .ulpi_nxt(ulpi_nxt), .ulpi_stp(ulpi_stp),
      .linestate(linestate), .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
      .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_done(tx_done)
   );

   always #5 ulpi_clk = ~ulpi_clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic cyc();
      @(posedge ulpi_clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) model_regs[i] = 8'h00;
      model_regs[0] = VID[7:0];
      model_regs[1] = VID[15:8];
      model_regs[2] = PID[7:0];
      model_regs[3] = PID[15:8];
   endtask

   function automatic logic [7:0] model_read(input logic [5:0] a);
      return (int'(a) < NREGS) ? model_regs[a] : 8'h00;
   endfunction

   // Entered at cycle 0 with the bus idle; returns in the following IDLE cycle
   task automatic do_read(input logic [5:0] a, input logic [1:0] ls_mid);
      logic [7:0] exp;
      exp = model_read(a);
      ulpi_data_in = {2'b11, a};
      cyc();
      check_output("rd_c1_dir_oe_nxt", {ulpi_direction, ulpi_data_oe, ulpi_nxt}, 3'b001);
      ulpi_data_in = 8'h00;
      cyc();
      check_output("rd_c2_dir_oe_nxt", {ulpi_direction, ulpi_data_oe, ulpi_nxt}, 3'b100);
      linestate = ls_mid;
      cyc();
      check_output("rd_c3_dir_oe_nxt", {ulpi_direction, ulpi_data_oe, ulpi_nxt}, 3'b110);
      check_output("rd_data", ulpi_data_out, exp);
      cyc();
      check_output("rd_c4_dir_oe_nxt", {ulpi_direction, ulpi_data_oe, ulpi_nxt}, 3'b000);
      cyc();
   endtask

   task automatic do_write(input logic [5:0] a, input logic [7:0] d);
      ulpi_data_in = {2'b10, a};
      cyc();
      check_output("wr_nxt_cmd", ulpi_nxt, 1'b1);
      cyc();
      check_output("wr_nxt_data", ulpi_nxt, 1'b1);
      ulpi_data_in = d;
      cyc();
      check_output("wr_nxt_stp", ulpi_nxt, 1'b0);
      ulpi_data_in = 8'h00;
      ulpi_stp = 1'b1;
      cyc();
      ulpi_stp = 1'b0;
      if (a >= 6'd4 && int'(a) < NREGS) model_regs[a] = d;
   endtask

   task automatic do_tx(input logic [5:0] cmd_low);
      logic [7:0] got [$];
      int n, i, gaps, done_cnt, post;
      logic first, stp_sent, consumed;
      n = tx_payload.size();
      i = 0; gaps = 0; done_cnt = 0; post = 0;
      first = 1'b1; stp_sent = 1'b0;
      ulpi_data_in = {2'b01, cmd_low};
      cyc();
      for (int c = 0; c < 60 && post < 3; c++) begin
         if (tx_valid) got.push_back(tx_data);
         if (tx_done) done_cnt++;
         if (done_cnt > 0) post++;
         consumed = 1'b0;
         if (first) begin
            first = 1'b0;
         end else if (i < n) begin
            ulpi_data_in = tx_payload[i];
            consumed = ulpi_nxt;
            if (!ulpi_nxt) gaps++;
         end else if (!stp_sent) begin
            ulpi_data_in = 8'h00;
            ulpi_stp = 1'b1;
            stp_sent = 1'b1;
            if (!ulpi_nxt) gaps++;
         end else begin
            ulpi_data_in = 8'h00;
            ulpi_stp = 1'b0;
         end
         cyc();
         if (consumed) i++;
      end
      ulpi_stp = 1'b0;
      ulpi_data_in = 8'h00;
      check_output("tx_count", got.size(), n + 1);
      if (got.size() == n + 1) begin
         check_output("tx_pid", got[0], {4'h0, cmd_low[3:0]});
         for (int k = 0; k < n; k++) check_output("tx_byte", got[k+1], tx_payload[k]);
      end
      check_output("tx_done_count", done_cnt, 1);
      check_output("tx_nxt_gaps", gaps, n / TX_GAP);
   endtask

   task automatic do_rx(input int gap_at);
      logic [7:0] got [$];
      int n, i, ready_cnt, first_dir, first_byte, last_ready, dir_fall;
      logic gap_now;
      n = rx_pkt.size();
      i = 0; ready_cnt = 0;
      first_dir = -1; first_byte = -1; last_ready = -1; dir_fall = -1;
      rx_valid = 1'b1;
      rx_data = rx_pkt[0];
      rx_last = (n == 1);
      for (int c = 1; c <= 60 && dir_fall < 0; c++) begin
         cyc();
         if (ulpi_direction && first_dir < 0) first_dir = c;
         if (!ulpi_direction && first_dir >= 0) dir_fall = c;
         if (ulpi_direction && ulpi_data_oe && ulpi_nxt) begin
            got.push_back(ulpi_data_out);
            if (first_byte < 0) first_byte = c;
         end
         if (ulpi_direction && ulpi_data_oe && !ulpi_nxt)
            check_output("rx_cmd_rxactive", ulpi_data_out[5:4], 2'b01);
         gap_now = 1'b0;
         if (rx_ready) begin
            ready_cnt++;
            i++;
            if (i == n) last_ready = c;
            gap_now = (i == gap_at);
         end
         if (gap_now || i >= n) begin
            rx_valid = 1'b0;
            rx_last = 1'b0;
         end else begin
            rx_valid = 1'b1;
            rx_data = rx_pkt[i];
            rx_last = (i == n - 1);
         end
      end
      rx_valid = 1'b0;
      rx_last = 1'b0;
      cyc();
      check_output("rx_dir_rise_cycle", first_dir, 1);
      check_output("rx_first_byte_cycle", first_byte, 3);
      check_output("rx_dir_fall_cycle", dir_fall, last_ready + 1);
      check_output("rx_ready_count", ready_cnt, n);
      check_output("rx_byte_count", got.size(), n);
      if (got.size() == n)
         for (int k = 0; k < n; k++) check_output("rx_byte", got[k], rx_pkt[k]);
   endtask

   // Waits for the RX CMD cycle, checks it, then checks the bus turns back
   task automatic wait_rxcmd(input logic [1:0] ls, output int waited);
      waited = -1;
      for (int k = 1; k <= 8 && waited < 0; k++) begin
         cyc();
         if (ulpi_direction && ulpi_data_oe) waited = k;
      end
      check_output("rxcmd_seen", waited >= 0, 1'b1);
      check_output("rxcmd_value", ulpi_data_out, 8'h0C | {6'd0, ls});
      check_output("rxcmd_nxt", ulpi_nxt, 1'b0);
      cyc();
      check_output("rxcmd_turn_out", ulpi_direction, 1'b0);
      cyc();
   endtask

   initial begin
      int waited;
      logic any_dir;
      logic [5:0] a;
      logic [7:0] d;
      int len;

      model_reset();
      repeat (3) cyc();
      check_output("reset_outputs",
         {ulpi_data_out, ulpi_data_oe, ulpi_direction, ulpi_nxt, rx_ready, tx_valid, tx_data, tx_done}, 0);
      ulpi_reset = 1'b0;
      cyc();

      do_read(6'h00, 2'b00);
      do_read(6'h03, 2'b00);
      do_read(6'h01, 2'b00);
      do_read(6'h02, 2'b00);
      do_read(6'h30, 2'b00);

      do_write(6'h0A, 8'hA5);
      do_read(6'h0A, 2'b00);
      do_write(6'h01, 8'hFF);
      do_read(6'h01, 2'b00);
      do_write(6'h20, 8'h55);
      do_read(6'h20, 2'b00);

      for (int r = 0; r < 12; r++) begin
         a = 6'($urandom_range(0, 20));
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(a, d);
         else do_read(a, 2'b00);
      end
      for (int r = 4; r < 8; r++) do_read(6'(r), 2'b00);

      tx_payload = '{8'h11, 8'h22, 8'h33};
      do_tx(6'h03);
      for (int r = 0; r < 4; r++) begin
         tx_payload.delete();
         len = $urandom_range(0, 6);
         for (int k = 0; k < len; k++) tx_payload.push_back(8'($urandom));
         do_tx(6'($urandom));
      end

      rx_pkt = '{8'h5A, 8'hC3, 8'h7E};
      do_rx(1);
      for (int r = 0; r < 4; r++) begin
         rx_pkt.delete();
         len = $urandom_range(1, 5);
         for (int k = 0; k < len; k++) rx_pkt.push_back(8'($urandom));
         do_rx((len > 1) ? $urandom_range(0, len - 1) : 0);
      end

      linestate = 2'b01;
      wait_rxcmd(2'b01, waited);
      check_output("ls_change_latency", waited, 2);
      any_dir = 1'b0;
      repeat (4) begin
         cyc();
         any_dir = any_dir | ulpi_direction;
      end
      check_output("ls_no_repeat", any_dir, 1'b0);

      do_read(6'h0A, 2'b10);
      wait_rxcmd(2'b10, waited);
      check_output("ls_pending_after_read", waited, 2);

      ulpi_data_in = {2'b11, 6'h0A};
      cyc();
      ulpi_data_in = 8'h00;
      cyc();
      cyc();
      check_output("rst_pre_dir_oe", {ulpi_direction, ulpi_data_oe}, 2'b11);
      #2 ulpi_reset = 1'b1;
      #1;
      check_output("rst_async_dir_oe_nxt", {ulpi_direction, ulpi_data_oe, ulpi_nxt}, 3'b000);
      model_reset();
      cyc();
      ulpi_reset = 1'b0;
      cyc();
      do_read(6'h0A, 2'b10);
      do_read(6'h00, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
